// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: store-op encodings and the queued store entry.
package mips_pkg;
  localparam logic [1:0] SOP_SW = 2'b00;
  localparam logic [1:0] SOP_SH = 2'b01;
  localparam logic [1:0] SOP_SB = 2'b10;

  // Entry address field is sized for the widest supported byte address.
  localparam int ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              be;
  } st_entry_t;
endpackage

// File: rtl/store_lane_gen.sv
// Combinational store narrowing: replicates data across lanes, builds byte enables, flags misalignment.
module store_lane_gen
  import mips_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  always_comb begin
    wdata    = data;
    be       = 4'b0000;
    misalign = 1'b0;
    case (op)
      SOP_SW: begin
        wdata    = data;
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      SOP_SH: begin
        wdata    = {2{data[15:0]}};
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      SOP_SB: begin
        wdata    = {4{data[7:0]}};
        be       = 4'b0001 << addr_lo;
        misalign = 1'b0;
      end
      default: begin
        wdata    = data;
        be       = 4'b0000;
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buf.sv
// MEM-stage store buffer: narrows stores, queues them in a FIFO, drains to data memory,
// and stalls loads that hit a pending store's word. ADDR_W must not exceed ENTRY_ADDR_W.
module store_narrow_buf
  import mips_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [1:0]               st_op,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_stall,
  output logic                     exc_align,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      lane_wdata;
  logic [3:0]       lane_be;
  logic             lane_misalign;
  logic             accept;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  st_entry_t        fifo [DEPTH];
  st_entry_t        head_entry;

  store_lane_gen u_lane_gen (
    .op       (st_op),
    .addr_lo  (st_addr[1:0]),
    .data     (st_data),
    .wdata    (lane_wdata),
    .be       (lane_be),
    .misalign (lane_misalign)
  );

  assign st_ready  = (count != FULL_CNT);
  assign accept    = st_valid & st_ready;
  // Misaligned or reserved stores complete the handshake but never enter the queue.
  assign push      = accept & ~lane_misalign;
  assign mem_valid = (count != '0);
  assign pop       = mem_valid & mem_ready;

  assign head_entry = fifo[head];
  assign mem_addr   = {head_entry.addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = head_entry.wdata;
  assign mem_be     = head_entry.be;

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      exc_align <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      exc_align <= accept & lane_misalign;
    end
  end

  // Entry storage carries no reset; occupancy is tracked solely by count/head/tail.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[tail].addr  <= ENTRY_ADDR_W'(st_addr);
      fifo[tail].wdata <= lane_wdata;
      fifo[tail].be    <= lane_be;
    end
  end

  // Occupied slots are those within count positions of head, modulo DEPTH.
  always_comb begin
    ld_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PTR_W'(PTR_W'(i) - head)} < count) &&
          (fifo[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]))
        ld_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_narrow_buf.sv
// Directed bench for store_narrow_buf: lane narrowing, misalignment, full/drain, load stall, reset.
module tb_store_narrow_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        exc_align;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  store_narrow_buf #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .ld_addr   (ld_addr),
    .ld_stall  (ld_stall),
    .exc_align (exc_align),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_op = 2'b00; st_addr = '0; st_data = '0;
    mem_ready = 1'b0; ld_addr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_exc", 32'(exc_align), 32'd0);
    check("rst_st_ready", 32'(st_ready), 32'd1);

    // SW aligned, pops the cycle after it is accepted
    mem_ready = 1'b1;
    drive_store(2'b00, 32'h100, 32'hDEADBEEF);
    step();
    st_valid = 1'b0;
    check("sw_mem_valid", 32'(mem_valid), 32'd1);
    check("sw_addr", mem_addr, 32'h100);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_be", 32'(mem_be), 32'hF);
    check("sw_count", 32'(count), 32'd1);
    step();
    check("sw_pop_count", 32'(count), 32'd0);
    check("sw_pop_valid", 32'(mem_valid), 32'd0);

    // SB at byte 3
    mem_ready = 1'b0;
    drive_store(2'b10, 32'h203, 32'h000000A5);
    step();
    st_valid = 1'b0;
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_addr", mem_addr, 32'h200);
    mem_ready = 1'b1;
    step();
    check("sb_pop_count", 32'(count), 32'd0);

    // SH upper half
    mem_ready = 1'b0;
    drive_store(2'b01, 32'h202, 32'h00001234);
    step();
    st_valid = 1'b0;
    check("sh_wdata", mem_wdata, 32'h12341234);
    check("sh_be", 32'(mem_be), 32'hC);
    mem_ready = 1'b1;
    step();
    check("sh_pop_count", 32'(count), 32'd0);

    // Misaligned SH, misaligned SW, reserved op
    drive_store(2'b01, 32'h201, 32'h1);
    step();
    st_valid = 1'b0;
    check("mis_sh_exc", 32'(exc_align), 32'd1);
    check("mis_sh_count", 32'(count), 32'd0);
    check("mis_sh_valid", 32'(mem_valid), 32'd0);
    step();
    check("mis_sh_exc_clear", 32'(exc_align), 32'd0);
    drive_store(2'b00, 32'h102, 32'h2);
    step();
    st_valid = 1'b0;
    check("mis_sw_exc", 32'(exc_align), 32'd1);
    check("mis_sw_count", 32'(count), 32'd0);
    step();
    drive_store(2'b11, 32'h100, 32'h3);
    step();
    st_valid = 1'b0;
    check("rsv_exc", 32'(exc_align), 32'd1);
    check("rsv_valid", 32'(mem_valid), 32'd0);
    step();
    check("rsv_exc_clear", 32'(exc_align), 32'd0);

    // Fill to DEPTH, third store is refused, then drain in order
    mem_ready = 1'b0;
    drive_store(2'b00, 32'h400, 32'h11111111);
    step();
    drive_store(2'b00, 32'h404, 32'h22222222);
    step();
    check("full_count", 32'(count), 32'd2);
    check("full_st_ready", 32'(st_ready), 32'd0);
    drive_store(2'b00, 32'h408, 32'h33333333);
    step();
    st_valid = 1'b0;
    check("full_hold_count", 32'(count), 32'd2);
    check("full_hold_addr", mem_addr, 32'h400);
    check("full_hold_wdata", mem_wdata, 32'h11111111);
    mem_ready = 1'b1;
    step();
    check("drain1_addr", mem_addr, 32'h404);
    check("drain1_wdata", mem_wdata, 32'h22222222);
    check("drain1_count", 32'(count), 32'd1);
    step();
    check("drain2_count", 32'(count), 32'd0);

    // Load stall against a pending SB; the store being accepted is excluded
    mem_ready = 1'b0;
    ld_addr = 32'h304;
    drive_store(2'b10, 32'h305, 32'h00000077);
    #1;
    check("stall_excl_accept", 32'(ld_stall), 32'd0);
    step();
    st_valid = 1'b0;
    #1;
    check("stall_hit", 32'(ld_stall), 32'd1);
    check("stall_sb_be", 32'(mem_be), 32'h2);
    check("stall_sb_wdata", mem_wdata, 32'h77777777);
    ld_addr = 32'h308;
    #1;
    check("stall_miss", 32'(ld_stall), 32'd0);
    ld_addr = 32'h304;
    mem_ready = 1'b1;
    step();
    check("stall_after_pop", 32'(ld_stall), 32'd0);

    // Push and pop together at count=1 (wrapped pointers)
    mem_ready = 1'b0;
    drive_store(2'b00, 32'h500, 32'h55555555);
    step();
    check("pp_pre_count", 32'(count), 32'd1);
    drive_store(2'b00, 32'h504, 32'h66666666);
    mem_ready = 1'b1;
    step();
    st_valid = 1'b0;
    mem_ready = 1'b0;
    check("pp_count", 32'(count), 32'd1);
    check("pp_addr", mem_addr, 32'h504);
    check("pp_wdata", mem_wdata, 32'h66666666);

    // Reset mid-drain drops the head even with mem_ready high
    mem_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_ready = 1'b0;
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_valid", 32'(mem_valid), 32'd0);
    check("rst_mid_ready", 32'(st_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
